// File: rtl/rvfpm_pkg.sv
// Shared types for the rvfpm result stage.
// Holds the buffered-result record and the field widths.
package rvfpm_pkg;

  localparam int FFLAGS_W     = 5;
  localparam int REG_ADDR_W   = 5;
  localparam int RVFPM_X_ID_W = 4;
  localparam int RVFPM_XLEN   = 32;

  typedef struct packed {
    logic [RVFPM_X_ID_W-1:0] id;
    logic [RVFPM_XLEN-1:0]   data;
    logic [REG_ADDR_W-1:0]   rd;
    logic                    we;
    logic [FFLAGS_W-1:0]     fflags;
  } rvfpm_result_t;

endpackage

// File: rtl/rvfpm_result_fifo.sv
// In-order synchronous FIFO of completed FPU results.
// The count is registered, so full/empty depend only on state and never on this cycle's pop.
module rvfpm_result_fifo
  import rvfpm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       ck,
  input  logic                       rst,
  input  logic                       push,
  input  rvfpm_result_t              push_data,
  input  logic                       pop,
  output rvfpm_result_t              pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  rvfpm_result_t      mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;

  // NOTE: state registers use non-blocking assignments so every always_ff
  // samples the pre-edge value of every other register.
  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the pointers
  // and count, so stale contents are never observed.
  always_ff @(posedge ck) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

  // An id may be present at most once; the head leaving this cycle does not count.
  always @(posedge ck) begin
    if (!rst && push) begin
      assert (!full);
      for (int k = 0; k < DEPTH; k++) begin
        if (CNT_W'(k) < count_q && !(pop && k == 0))
          assert (mem[rd_ptr + PTR_W'(k)].id != push_data.id);
      end
    end
    if (!rst && pop) assert (!empty);
  end

endmodule

// File: rtl/rvfpm_result_stage.sv
// In-order result buffer between the rvfpm core and the CORE-V-XIF result channel.
// Define RVFPM_RESULT_BYPASS_EN to let a pre-committed result skip an empty FIFO.
module rvfpm_result_stage
  import rvfpm_pkg::*;
#(
  parameter int X_ID_WIDTH = RVFPM_X_ID_W,
  parameter int XLEN       = RVFPM_XLEN,
  parameter int DEPTH      = 4
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [X_ID_WIDTH-1:0] in_id,
  input  logic [XLEN-1:0]       in_data,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_we,
  input  logic [FFLAGS_W-1:0]   in_fflags,
  input  logic                  commit_valid,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic                  commit_kill,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [X_ID_WIDTH-1:0] result_id,
  output logic [XLEN-1:0]       result_data,
  output logic [REG_ADDR_W-1:0] result_rd,
  output logic                  result_we,
  output logic [FFLAGS_W-1:0]   result_fflags,
  output logic                  empty
);

  localparam int NUM_IDS = 1 << X_ID_WIDTH;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  rvfpm_result_t       in_entry;
  rvfpm_result_t       head;
  rvfpm_result_t       out_q;
  logic                out_valid_q;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_push;
  logic                push;
  logic                out_free;
  logic                retire;
  logic                retire_load;
  logic                bypass_hit;
  logic                bypass_load;
  logic [NUM_IDS-1:0]  seen_q;
  logic [NUM_IDS-1:0]  kill_q;

  assign in_entry = '{id: in_id, data: in_data, rd: in_rd, we: in_we, fflags: in_fflags};

  assign in_ready    = !fifo_full;
  assign push        = in_valid && in_ready;
  assign out_free    = !out_valid_q || result_ready;
  assign retire      = !fifo_empty && seen_q[head.id] && out_free;
  assign retire_load = retire && !kill_q[head.id];

`ifdef RVFPM_RESULT_BYPASS_EN
  // Only an empty FIFO may be skipped, otherwise ordering would break.
  assign bypass_hit = push && fifo_empty && seen_q[in_id] && out_free;
`else
  assign bypass_hit = 1'b0;
`endif
  assign bypass_load = bypass_hit && !kill_q[in_id];
  assign fifo_push   = push && !bypass_hit;

  rvfpm_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .ck        (ck),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (in_entry),
    .pop       (retire),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A commit landing on an id that is consumed this cycle re-arms that row.
  always_ff @(posedge ck) begin
    if (rst) begin
      seen_q <= '0;
      kill_q <= '0;
    end else begin
      if (retire) begin
        seen_q[head.id] <= 1'b0;
        kill_q[head.id] <= 1'b0;
      end
      if (bypass_hit) begin
        seen_q[in_id] <= 1'b0;
        kill_q[in_id] <= 1'b0;
      end
      if (commit_valid) begin
        seen_q[commit_id] <= 1'b1;
        kill_q[commit_id] <= commit_kill;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (retire_load) begin
      out_valid_q <= 1'b1;
      out_q       <= head;
    end else if (bypass_load) begin
      out_valid_q <= 1'b1;
      out_q       <= in_entry;
    end else if (result_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign result_valid  = out_valid_q;
  assign result_id     = out_q.id;
  assign result_data   = out_q.data;
  assign result_rd     = out_q.rd;
  assign result_we     = out_q.we;
  assign result_fflags = out_q.fflags;
  assign empty         = (fifo_count == '0) && !out_valid_q;

  always @(posedge ck) begin
    if (!rst && commit_valid)
      assert (!seen_q[commit_id]
              || (retire && head.id == commit_id)
              || (bypass_hit && in_id == commit_id));
  end

endmodule

// File: tb/tb_rvfpm_result_stage.sv
// Scoreboard bench for rvfpm_result_stage: directed scenarios plus randomized batches.
// Expected output order = push order with killed results removed.
module tb_rvfpm_result_stage;
  import rvfpm_pkg::*;

  logic        ck = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_id;
  logic [31:0] in_data;
  logic [4:0]  in_rd;
  logic        in_we;
  logic [4:0]  in_fflags;
  logic        commit_valid;
  logic [3:0]  commit_id;
  logic        commit_kill;
  logic        result_valid;
  logic        result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we;
  logic [4:0]  result_fflags;
  logic        empty;

  rvfpm_result_stage dut (
    .ck            (ck),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_id         (in_id),
    .in_data       (in_data),
    .in_rd         (in_rd),
    .in_we         (in_we),
    .in_fflags     (in_fflags),
    .commit_valid  (commit_valid),
    .commit_id     (commit_id),
    .commit_kill   (commit_kill),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result_id     (result_id),
    .result_data   (result_data),
    .result_rd     (result_rd),
    .result_we     (result_we),
    .result_fflags (result_fflags),
    .empty         (empty)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pushed results in order, plus per-id commit decisions.
  rvfpm_result_t pend[$];
  bit            committed [16];
  bit            killed    [16];

  task automatic model_clear();
    pend.delete();
    for (int i = 0; i < 16; i++) begin
      committed[i] = 1'b0;
      killed[i]    = 1'b0;
    end
  endtask

  // Ready pattern: 0 = constant ready_val, 1 = toggle, 2 = random.
  int   rmode     = 0;
  logic ready_val = 1'b1;

  always @(posedge ck) begin
    #1;
    case (rmode)
      0:       result_ready = ready_val;
      1:       result_ready = !result_ready;
      default: result_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor: stability while stalled, and in-order content on every transfer.
  logic          hold = 1'b0;
  logic [46:0]   snap;
  rvfpm_result_t exp_r;

  always @(negedge ck) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold)
        check("stable_while_stalled",
              {result_valid, result_id, result_data, result_rd, result_we, result_fflags},
              {1'b1, snap});
      if (result_valid && result_ready) begin
        while (pend.size() != 0 && committed[pend[0].id] && killed[pend[0].id]) begin
          committed[pend[0].id] = 1'b0;
          killed[pend[0].id]    = 1'b0;
          void'(pend.pop_front());
        end
        check("result_expected", pend.size() != 0, 1);
        if (pend.size() != 0) begin
          exp_r = pend.pop_front();
          check("result_committed", committed[exp_r.id], 1);
          check("result_content",
                {result_id, result_data, result_rd, result_we, result_fflags}, exp_r);
          committed[exp_r.id] = 1'b0;
        end
      end
      hold = result_valid && !result_ready;
      snap = {result_id, result_data, result_rd, result_we, result_fflags};
    end
  end

  // One clock of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input bit p, input logic [3:0] pid, input logic [31:0] pd,
                      input bit c, input logic [3:0] cid, input bit ckill,
                      output bit acc);
    rvfpm_result_t r;
    in_valid     = p;
    in_id        = pid;
    in_data      = pd;
    in_rd        = 5'($urandom);
    in_we        = 1'($urandom);
    in_fflags    = 5'($urandom);
    commit_valid = c;
    commit_id    = cid;
    commit_kill  = ckill;
    acc = p && in_ready;
    if (acc) begin
      r = '{id: pid, data: pd, rd: in_rd, we: in_we, fflags: in_fflags};
      pend.push_back(r);
    end
    if (c) begin
      committed[cid] = 1'b1;
      killed[cid]    = ckill;
    end
    @(posedge ck);
    #1;
    in_valid     = 1'b0;
    commit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, acc);
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] d);
    bit acc;
    step(1, id, d, 0, 0, 0, acc);
  endtask

  task automatic commit(input logic [3:0] id, input bit k);
    bit acc;
    step(0, 0, 0, 1, id, k, acc);
  endtask

  // Wait (bounded) for drain, then any leftover model entries must all be killed.
  task automatic drain(input string name);
    int n = 0;
    while (!empty && n < 200) begin
      @(posedge ck);
      #1;
      n++;
    end
    check({name, "_drained"}, empty, 1);
    while (pend.size() != 0 && committed[pend[0].id] && killed[pend[0].id])
      void'(pend.pop_front());
    check({name, "_no_leftover"}, pend.size(), 0);
    model_clear();
  endtask

  int   lat;
  int   ids [6];
  int   perm[6];
  bit   accepted;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_id = '0; in_data = '0; in_rd = '0; in_we = 1'b0; in_fflags = '0;
    commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
    result_ready = 1'b1;
    model_clear();
    repeat (2) @(posedge ck);
    #1;
    check("reset_result_valid", result_valid, 0);
    check("reset_result_fields", {result_id, result_data, result_rd, result_we, result_fflags}, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_empty", empty, 1);
    rst = 1'b0;
    idle(1);

    // Commit before push: latency from push to result_valid.
    commit(3, 0);
    idle(1);
    push(3, 32'h3F80_0000);
    lat = 1;
    while (!result_valid && lat < 10) begin
      @(posedge ck);
      #1;
      lat++;
    end
`ifdef RVFPM_RESULT_BYPASS_EN
    check("latency_commit_first", lat, 1);
`else
    check("latency_commit_first", lat, 2);
`endif
    check("latency_id", result_id, 3);
    drain("latency");

    // Out-of-order commits must not reorder output.
    push(1, 32'h1111_0001);
    push(2, 32'h2222_0002);
    commit(2, 0);
    for (int i = 0; i < 3; i++) begin
      check("no_result_before_head_commit", result_valid, 0);
      idle(1);
    end
    commit(1, 0);
    lat = 0;
    while (!result_valid && lat < 10) begin
      @(posedge ck);
      #1;
      lat++;
    end
    check("order_first", {result_valid, result_id}, {1'b1, 4'd1});
    idle(1);
    check("order_second_b2b", {result_valid, result_id}, {1'b1, 4'd2});
    drain("order");

    // Killed result is dropped silently.
    push(5, 32'h5555_5555);
    commit(5, 1);
    check("kill_not_yet_empty", empty, 0);
    idle(1);
    check("kill_empty", empty, 1);
    for (int i = 0; i < 3; i++) begin
      check("kill_no_result", result_valid, 0);
      idle(1);
    end
    drain("kill");

    // Fill with no commits and backpressure, then drain.
    ready_val = 1'b0;
    idle(2);
    for (int i = 0; i < 4; i++) push(4'(8 + i), 32'hA000_0000 + 32'(i));
    check("full_in_ready", in_ready, 0);
    step(1, 12, 32'hDEAD_BEEF, 0, 0, 0, accepted);
    check("full_fifth_held", accepted, 0);
    check("full_still_not_ready", in_ready, 0);
    for (int i = 0; i < 4; i++) commit(4'(8 + i), 0);
    idle(3);
    check("full_held_head", {result_valid, result_id, result_data}, {1'b1, 4'd8, 32'hA000_0000});
    ready_val = 1'b1;
    drain("full");
    check("full_in_ready_again", in_ready, 1);

    // Synchronous reset mid-operation discards buffered results and commits.
    ready_val = 1'b0;
    idle(2);
    push(1, 32'h0101_0101);
    push(2, 32'h0202_0202);
    commit(3, 0);
    commit(1, 0);
    idle(1);
    rst = 1'b1;
    @(posedge ck);
    #1;
    rst = 1'b0;
    model_clear();
    check("rst_result_valid", result_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_in_ready", in_ready, 1);
    ready_val = 1'b1;
    commit(2, 0);
    for (int i = 0; i < 4; i++) begin
      check("rst_commit_alone_no_result", result_valid, 0);
      idle(1);
    end
    push(2, 32'h2020_2020);
    drain("rst");

    // Toggling ready with three committed results.
    rmode = 1;
    push(4, 32'h4444_0004);
    push(6, 32'h6666_0006);
    push(7, 32'h7777_0007);
    commit(6, 0);
    commit(4, 0);
    commit(7, 0);
    drain("toggle");
    rmode = 0;
    idle(2);

    // Randomized batches: distinct ids per batch, random commit order and kills.
    rmode = 2;
    for (int b = 0; b < 40; b++) begin
      int k, pi, ci, n, t;
      bit p, c;
      k = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) begin
        ids[i]  = (b * 6 + i) % 16;
        perm[i] = i;
      end
      for (int i = k - 1; i > 0; i--) begin
        int j;
        j = $urandom_range(0, i);
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      pi = 0; ci = 0; n = 0;
      while ((pi < k || ci < k) && n < 300) begin
        p = (pi < k) && ($urandom_range(0, 1) == 1);
        c = (ci < k) && ($urandom_range(0, 1) == 1);
        step(p, 4'(ids[pi < k ? pi : 0]), $urandom, c, 4'(ids[perm[ci < k ? ci : 0]]),
             ($urandom_range(0, 3) == 0), accepted);
        if (accepted) pi++;
        if (c) ci++;
        n++;
      end
      check("random_batch_issued", (pi == k) && (ci == k), 1);
      drain("random");
    end
    rmode = 0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
